// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared JK encodings and parameter limits for the JK counter
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_fn_e;

    localparam int WIDTH_MIN   = 2;
    localparam int WIDTH_MAX   = 16;
    localparam int MODULUS_MIN = 2;

    function automatic int modulus_max(input int width);
        return 1 << width;
    endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// rtl/jk_ff_cell.sv - rising-edge JK flip-flop with synchronous active-low clear
module jk_ff_cell
    import jk_pkg::*;
(
    input  logic C,
    input  logic RESETn,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Qn
);

    logic [1:0] jk;
    assign jk = {J, K};

    always_ff @(posedge C) begin
        if (!RESETn) begin
            Q <= 1'b0;
        end else begin
            case (jk)
                JK_HOLD: Q <= Q;
                JK_CLR:  Q <= 1'b0;
                JK_SET:  Q <= 1'b1;
                JK_TGL:  Q <= ~Q;
                default: Q <= Q;
            endcase
        end
    end

    assign Qn = ~Q;

endmodule

// File: rtl/jk_counter_mod.sv
// rtl/jk_counter_mod.sv - modulo up/down counter with load, built from JK cells
module jk_counter_mod
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             C,
    input  logic             RESETn,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             TC
);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
            MODULUS < MODULUS_MIN || MODULUS > modulus_max(WIDTH)) begin : g_bad_params
            $error("jk_counter_mod: illegal WIDTH/MODULUS combination");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] inc;
    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             d_ok;

    // A full-range modulus cannot see an out-of-range load value.
    generate
        if (MODULUS == modulus_max(WIDTH)) begin : g_full
            assign d_ok = 1'b1;
        end else begin : g_part
            assign d_ok = (D <= MAX);
        end
    endgenerate

    assign inc = (q == MAX)   ? '0  : q + 1'b1;
    assign dec = (q == '0)    ? MAX : q - 1'b1;

    always_comb begin
        n = q;
        if (!RESETn) begin
            n = '0;
        end else if (LOAD) begin
            n = d_ok ? D : '0;
        end else if (EN) begin
            n = UP ? inc : dec;
        end
    end

    assign j = n & ~q;
    assign k = ~n & q;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            jk_ff_cell u_cell (
                .C      (C),
                .RESETn (RESETn),
                .J      (j[i]),
                .K      (k[i]),
                .Q      (q[i]),
                .Qn     (qn[i])
            );
        end
    endgenerate

    assign Q  = q;
    assign Qn = qn;
    assign TC = RESETn & EN & ~LOAD & (UP ? (q == MAX) : (q == '0));

endmodule
